// File: rtl/dstream_pkg.sv
// Shared definitions for dstream link stages: count sizing, parameter checks
// and the per-cycle FIFO operation encoding.
package dstream_pkg;

    // Bit-pattern of {push, pop} in a given cycle.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/dstream.sv
// dstream link: valid/ready/data handshake. A word transfers on any rising
// clock edge where valid and ready are both high; the sender holds valid and
// data stable until that happens, and ready may not depend on valid.
interface dstream #(
    parameter int N = 30
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    // Consumer side of the link.
    modport in (
        input  valid,
        input  data,
        output ready
    );

    // Producer side of the link.
    modport out (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

    modport master (
        output valid,
        output data,
        input  ready
    );

endinterface

// File: rtl/dstream_fifo_mem.sv
// Storage array for dstream_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module dstream_fifo_mem #(
    parameter int N     = 30,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [N-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [N-1:0]             rdata
);

    logic [N-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read gives first-word-fall-through on the output.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dstream_fifo.sv
// Elastic first-word-fall-through buffer between two dstream links, with
// occupancy, almost-full status and synchronous flush.
module dstream_fifo
    import dstream_pkg::*;
#(
    parameter int N        = 30,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    dstream.in                            x,
    dstream.out                           y,
    input  logic                          flush,
    output logic [clog2_cnt(DEPTH)-1:0]   count,
    output logic                          almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2_cnt(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("dstream_fifo: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_af_chk
        $error("dstream_fifo: AF_LEVEL=%0d outside 1..DEPTH", AF_LEVEL);
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          almost_full_q;
    logic          full, empty;
    logic          push, pop;
    fifo_op_e      op;
    logic [N-1:0]  rdata;

    // Ready comes only from registered state, so no comb path from y.ready.
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign x.ready = !full && reset_n;
    assign y.valid = !empty && reset_n;
    assign y.data  = rdata;

    assign push = x.valid && x.ready;
    assign pop  = y.valid && y.ready;
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end
                OP_POP: begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                end
                OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            // Looked up from next-state so it tracks count in the same cycle.
            almost_full_q <= (count_d >= AF_CNT);
        end
    end

    assign count       = count_q;
    assign almost_full = almost_full_q;

    // A flushed push must not land in the array either.
    dstream_fifo_mem #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (x.data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dstream_fifo.sv
// Bench for dstream_fifo: directed table and sequences on a DEPTH=8 instance,
// randomized traffic against a queue model on DEPTH=2 and DEPTH=16 instances.
module tb_dstream_fifo;

    localparam int N = 30;

    logic clk;
    logic reset_n;
    logic flush;
    logic [3:0] count;
    logic almost_full;
    int n_tests;
    int n_fail;
    bit rand_go;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dstream #(.N(N)) xm ();
    dstream #(.N(N)) ym ();

    dstream_fifo #(
        .N     (N),
        .DEPTH (8)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (xm),
        .y           (ym),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input int c, input bit xr, input bit yv, input bit af);
        check({name, "_count"}, 32'(count), 32'(c));
        check({name, "_xready"}, 32'(xm.ready), 32'(xr));
        check({name, "_yvalid"}, 32'(ym.valid), 32'(yv));
        check({name, "_af"}, 32'(almost_full), 32'(af));
    endtask

    // Upstream obligation: a pending word stays valid and stable until taken.
    bit mon_pend;
    logic [N-1:0] mon_data;
    initial mon_pend = 1'b0;
    always @(posedge clk) begin
        if (reset_n && mon_pend && (!xm.valid || (xm.data !== mon_data))) begin
            n_fail++;
            $display("FAIL upstream_hold: valid=%0b data=0x%0h required held 0x%0h", xm.valid, xm.data, mon_data);
        end
        mon_pend = reset_n && xm.valid && !xm.ready;
        mon_data = xm.data;
    end

    typedef struct {
        bit            xv;
        logic [N-1:0]  xd;
        bit            yr;
        int            exp_count;
        bit            exp_xready;
        bit            exp_yvalid;
        bit            exp_af;
        logic [N-1:0]  exp_ydata;
    } vec_t;

    // Randomized traffic on two other geometries, AF_LEVEL=1.
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int D  = (g == 0) ? 2 : 16;
        localparam int CR = $clog2(D + 1);
        dstream #(.N(N)) xr ();
        dstream #(.N(N)) yr ();
        logic [CR-1:0] cnt;
        logic af;
        bit done;

        dstream_fifo #(
            .N        (N),
            .DEPTH    (D),
            .AF_LEVEL (1)
        ) u_dut_r (
            .clk         (clk),
            .reset_n     (reset_n),
            .x           (xr),
            .y           (yr),
            .flush       (1'b0),
            .count       (cnt),
            .almost_full (af)
        );

        initial begin
            logic [N-1:0] exp_q[$];
            bit hold;
            bit push;
            bit pop;
            done = 1'b0;
            hold = 1'b0;
            xr.valid = 1'b0;
            xr.data = '0;
            yr.ready = 1'b0;
            wait (rand_go);
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk);
                #1;
                check("rand_count", 32'(cnt), 32'(exp_q.size()));
                check("rand_xready", 32'(xr.ready), 32'(exp_q.size() != D));
                check("rand_yvalid", 32'(yr.valid), 32'(exp_q.size() != 0));
                check("rand_af", 32'(af), 32'(exp_q.size() >= 1));
                if (exp_q.size() != 0) check("rand_ydata", 32'(yr.data), 32'(exp_q[0]));
                if (!hold) begin
                    xr.valid = ($urandom_range(0, 1) == 1);
                    xr.data = N'($urandom);
                end
                yr.ready = ($urandom_range(0, 99) < 30);
                push = xr.valid && (exp_q.size() != D);
                pop = (exp_q.size() != 0) && yr.ready;
                hold = xr.valid && !push;
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(xr.data);
            end
            xr.valid = 1'b0;
            yr.ready = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [N-1:0] drain_exp[8];
        n_tests = 0;
        n_fail = 0;
        rand_go = 1'b0;
        reset_n = 1'b0;
        flush = 1'b0;
        xm.valid = 1'b1;
        xm.data = N'(32'h55);
        ym.ready = 1'b0;

        // Reset held with a word offered upstream.
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state("reset", 0, 1'b0, 1'b0, 1'b0);
        end
        xm.valid = 1'b0;
        reset_n = 1'b1;
        tick();
        check_state("post_reset", 0, 1'b1, 1'b0, 1'b0);

        // Fill to full with the consumer stalled, then drain in order.
        for (int i = 0; i < 8; i++) begin
            v = '{1'b1, N'(i + 1), 1'b0, i + 1, (i + 1) != 8, 1'b1, (i + 1) >= 6, N'(1)};
            vecs.push_back(v);
        end
        v = '{1'b0, N'(0), 1'b0, 8, 1'b0, 1'b1, 1'b1, N'(1)};
        vecs.push_back(v);
        for (int j = 0; j < 8; j++) begin
            v = '{1'b0, N'(0), 1'b1, 7 - j, 1'b1, (7 - j) != 0, (7 - j) >= 6, N'(j + 2)};
            vecs.push_back(v);
        end
        foreach (vecs[i]) begin
            xm.valid = vecs[i].xv;
            xm.data = vecs[i].xd;
            ym.ready = vecs[i].yr;
            tick();
            check_state("table", vecs[i].exp_count, vecs[i].exp_xready, vecs[i].exp_yvalid, vecs[i].exp_af);
            if (vecs[i].exp_yvalid) check("table_ydata", 32'(ym.data), 32'(vecs[i].exp_ydata));
        end
        xm.valid = 1'b0;
        ym.ready = 1'b0;

        // Full plus one pop: ready reopens only the following cycle.
        for (int i = 0; i < 8; i++) begin
            xm.valid = 1'b1;
            xm.data = N'(32'h11 + i);
            tick();
        end
        xm.data = N'(32'h99);
        ym.ready = 1'b1;
        #1;
        check("full_pop_xready_same", 32'(xm.ready), 32'd0);
        check("full_pop_count_before", 32'(count), 32'd8);
        tick();
        check("full_pop_count_after", 32'(count), 32'd7);
        check("full_pop_xready_next", 32'(xm.ready), 32'd1);
        ym.ready = 1'b0;
        tick();
        check("full_refill_count", 32'(count), 32'd8);
        check("full_refill_xready", 32'(xm.ready), 32'd0);
        xm.valid = 1'b0;
        ym.ready = 1'b1;
        for (int i = 0; i < 7; i++) drain_exp[i] = N'(32'h12 + i);
        drain_exp[7] = N'(32'h99);
        for (int i = 0; i < 8; i++) begin
            check("full_drain_yvalid", 32'(ym.valid), 32'd1);
            check("full_drain_ydata", 32'(ym.data), 32'(drain_exp[i]));
            tick();
        end
        check_state("full_drained", 0, 1'b1, 1'b0, 1'b0);
        ym.ready = 1'b0;

        // Flush with a simultaneous push and pop: both are discarded.
        for (int i = 0; i < 5; i++) begin
            xm.valid = 1'b1;
            xm.data = N'(32'h21 + i);
            tick();
        end
        xm.valid = 1'b0;
        check("flush_pre_count", 32'(count), 32'd5);
        flush = 1'b1;
        xm.valid = 1'b1;
        xm.data = N'(32'hAA);
        ym.ready = 1'b1;
        tick();
        flush = 1'b0;
        xm.valid = 1'b0;
        ym.ready = 1'b0;
        check_state("flush", 0, 1'b1, 1'b0, 1'b0);
        tick();
        check("flush_stays_empty", 32'(ym.valid), 32'd0);
        xm.valid = 1'b1;
        xm.data = N'(32'h31);
        tick();
        xm.valid = 1'b0;
        check("flush_next_count", 32'(count), 32'd1);
        check("flush_next_ydata", 32'(ym.data), 32'h31);
        ym.ready = 1'b1;
        tick();
        check("flush_next_drained", 32'(count), 32'd0);

        // Continuous streaming: one word per cycle after one cycle of latency.
        xm.valid = 1'b1;
        ym.ready = 1'b1;
        check("stream_start_yvalid", 32'(ym.valid), 32'd0);
        for (int k = 0; k < 1000; k++) begin
            xm.data = N'(1000 + k);
            tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_yvalid", 32'(ym.valid), 32'd1);
            check("stream_ydata", 32'(ym.data), 32'(1000 + k));
        end
        xm.valid = 1'b0;
        tick();
        check("stream_end_count", 32'(count), 32'd0);
        ym.ready = 1'b0;

        rand_go = 1'b1;
        for (int t = 0; t < 10000 && !(g_rand[0].done && g_rand[1].done); t++) @(posedge clk);
        check("rand_finished", 32'(g_rand[0].done && g_rand[1].done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
